// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_if                                                       |
// | Byte-stream valid/ready handshake feeding the instruction loader.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader                                                          |
// | Assembles a little-endian byte stream into the instruction array and |
// | holds the core in reset until a complete program has been written.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              load_start,
    input  wire  [CNT_W-1:0] word_count,
    imem_loader_if.slave     byte_if,
    output logic [31:0]      inst_mem [0:DEPTH-1],
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int               c_ADDR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [31:0]         r_mem [0:DEPTH-1];
    logic [23:0]         r_staged;
    logic [1:0]          r_idx;
    logic [c_ADDR_W-1:0] r_wr_addr;
    logic [CNT_W-1:0]    r_target;
    logic [CNT_W-1:0]    r_words;
    logic                r_ready;
    logic                r_busy;
    logic                r_core_reset;
    logic                r_done;
    logic                r_error;

    logic w_start_ok;
    logic w_accept;
    logic w_last_word;

    assign w_start_ok  = (word_count != '0) && (word_count <= c_DEPTH_CNT);
    assign w_accept    = r_ready & byte_if.byte_valid;
    assign w_last_word = ((r_words + CNT_W'(1)) == r_target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_staged     <= '0;
            r_idx        <= '0;
            r_wr_addr    <= '0;
            r_target     <= '0;
            r_words      <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    // A rejected start only flags the error; a DONE core keeps running.
                    if (load_start) begin
                        if (w_start_ok) begin
                            r_state      <= c_ST_LOAD;
                            r_idx        <= '0;
                            r_wr_addr    <= '0;
                            r_words      <= '0;
                            r_target     <= word_count;
                            r_ready      <= 1'b1;
                            r_busy       <= 1'b1;
                            r_core_reset <= 1'b1;
                            r_done       <= 1'b0;
                            r_error      <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        case (r_idx)
                            2'd0: r_staged[7:0]   <= byte_if.byte_data;
                            2'd1: r_staged[15:8]  <= byte_if.byte_data;
                            2'd2: r_staged[23:16] <= byte_if.byte_data;
                            default: begin
                                r_mem[r_wr_addr] <= {byte_if.byte_data, r_staged};
                                r_wr_addr        <= r_wr_addr + c_ADDR_W'(1);
                                r_words          <= r_words + CNT_W'(1);
                                // The wrapped write address is never used after the last word.
                                if (w_last_word) begin
                                    r_state      <= c_ST_DONE;
                                    r_ready      <= 1'b0;
                                    r_busy       <= 1'b0;
                                    r_core_reset <= 1'b0;
                                    r_done       <= 1'b1;
                                end
                            end
                        endcase
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_ready      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_core_reset <= 1'b1;
                end
            endcase
        end
    end

    assign byte_if.byte_ready = r_ready;
    assign inst_mem           = r_mem;
    assign core_reset         = r_core_reset;
    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;
    assign words_loaded       = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader                                                       |
// | Scoreboard bench: stimulus queues expectations, a monitor compares.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int CNT_W = 11;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             load_start = 1'b0;
    logic [CNT_W-1:0] word_count = '0;
    logic [31:0]      inst_mem [0:DEPTH-1];
    logic             core_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .word_count   (word_count),
        .byte_if      (bus.slave),
        .inst_mem     (inst_mem),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef enum int {F_CORE, F_READY, F_BUSY, F_DONE, F_ERR, F_WORDS, F_MEM} field_e;
    typedef struct {
        field_e      f;
        int          addr;
        logic [31:0] exp;
    } exp_t;

    exp_t mem_q[$];
    exp_t stat_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   snap_req = 0;
    int   snap_ack = 0;
    bit   drain    = 1'b0;
    bit   done_q   = 1'b0;

    function automatic logic [31:0] actual(exp_t e);
        case (e.f)
            F_CORE:  return 32'(core_reset);
            F_READY: return 32'(bus.byte_ready);
            F_BUSY:  return 32'(busy);
            F_DONE:  return 32'(done);
            F_ERR:   return 32'(error);
            F_WORDS: return 32'(words_loaded);
            default: return inst_mem[e.addr];
        endcase
    endfunction

    task automatic compare(exp_t e);
        logic [31:0] act;
        act = actual(e);
        n_vec++;
        if (act !== e.exp) begin
            n_err++;
            $display("FAIL %s[%0d]: actual %h, required %h", e.f.name(), e.addr, act, e.exp);
        end
    endtask

    // Monitor: memory expectations resolve when a load completes, status ones on request.
    always @(negedge clk) begin
        if (done === 1'b1 && !done_q) begin
            while (mem_q.size() > 0) compare(mem_q.pop_front());
        end
        done_q = (done === 1'b1);
        if (snap_ack != snap_req) begin
            while (stat_q.size() > 0) compare(stat_q.pop_front());
            if (drain) begin
                while (mem_q.size() > 0) begin
                    exp_t e;
                    e = mem_q.pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_pending[%0d]: load never completed, required %h", e.addr, e.exp);
                end
            end
            snap_ack = snap_req;
        end
    end

    task automatic exp_stat(field_e f, int addr, logic [31:0] v);
        exp_t e;
        e.f = f; e.addr = addr; e.exp = v;
        stat_q.push_back(e);
    endtask

    task automatic exp_mem(int addr, logic [31:0] v);
        exp_t e;
        e.f = F_MEM; e.addr = addr; e.exp = v;
        mem_q.push_back(e);
    endtask

    task automatic snap();
        int k;
        k = 0;
        snap_req++;
        while (snap_ack != snap_req && k < 5) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (snap_ack != snap_req) begin
            n_vec++;
            n_err++;
            $display("FAIL snapshot_timeout: actual pending, required serviced");
            stat_q.delete();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Junk byte offered in the start cycle must not be accepted.
    task automatic start(int n);
        load_start     = 1'b1;
        word_count     = CNT_W'(n);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        cyc();
        load_start     = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        bit acc;
        int k;
        k = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        do begin
            acc = bus.byte_ready;
            cyc();
            k++;
        end while (!acc && k < 20);
        bus.byte_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_timeout: actual not accepted, required accepted %h", b);
        end
    endtask

    task automatic send_word(logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic exp_status(bit c, bit r, bit b, bit d, bit e);
        exp_stat(F_CORE, 0, 32'(c));
        exp_stat(F_READY, 0, 32'(r));
        exp_stat(F_BUSY, 0, 32'(b));
        exp_stat(F_DONE, 0, 32'(d));
        exp_stat(F_ERR, 0, 32'(e));
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset state
        exp_status(1, 0, 0, 0, 0);
        exp_stat(F_WORDS, 0, 0);
        exp_stat(F_MEM, 0, 0);
        exp_stat(F_MEM, 1023, 0);
        snap();

        // Two words, back-to-back bytes 01..08
        start(2);
        exp_mem(0, 32'h04030201);
        exp_mem(1, 32'h08070605);
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        exp_status(1, 1, 1, 0, 0);
        snap();
        send_byte(8'h08);
        exp_status(0, 0, 0, 1, 0);
        exp_stat(F_WORDS, 0, 2);
        snap();

        // One word with gaps in byte_valid
        start(1);
        exp_mem(0, 32'hDEADBEEF);
        send_byte(8'hEF); cyc();
        send_byte(8'hBE); cyc();
        send_byte(8'hAD); cyc();
        exp_stat(F_MEM, 0, 32'h04030201);
        exp_stat(F_MEM, 1, 32'h08070605);
        exp_stat(F_WORDS, 0, 0);
        exp_stat(F_BUSY, 0, 1);
        snap();
        send_byte(8'hDE);
        exp_status(0, 0, 0, 1, 0);
        exp_stat(F_WORDS, 0, 1);
        snap();

        // Illegal starts from DONE
        start(0);
        exp_status(0, 0, 0, 1, 1);
        exp_stat(F_WORDS, 0, 1);
        exp_stat(F_MEM, 0, 32'hDEADBEEF);
        snap();
        start(1025);
        exp_status(0, 0, 0, 1, 1);
        exp_stat(F_MEM, 1, 32'h08070605);
        snap();

        // Legal start clears error; reset after 6 bytes of a 3-word load
        start(3);
        exp_status(1, 1, 1, 0, 0);
        exp_stat(F_WORDS, 0, 0);
        snap();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
        reset = 1'b1;
        exp_status(1, 0, 0, 0, 0);
        exp_stat(F_WORDS, 0, 0);
        exp_stat(F_MEM, 0, 0);
        exp_stat(F_MEM, 1, 0);
        snap();
        cyc();
        reset = 1'b0;

        // Clean load after reset
        start(2);
        exp_mem(0, 32'h11223344);
        exp_mem(1, 32'h55667788);
        send_word(32'h11223344);
        send_word(32'h55667788);
        exp_status(0, 0, 0, 1, 0);
        exp_stat(F_WORDS, 0, 2);
        exp_stat(F_MEM, 2, 0);
        snap();

        // Full-depth load, word i = i*4
        start(1024);
        exp_mem(0, 32'h0);
        exp_mem(1, 32'h4);
        exp_mem(511, 32'h7FC);
        exp_mem(1023, 32'hFFC);
        for (int i = 0; i < DEPTH; i++) send_word(32'(i * 4));
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hFF;
        repeat (4) cyc();
        bus.byte_valid = 1'b0;
        exp_status(0, 0, 0, 1, 0);
        exp_stat(F_WORDS, 0, 32'h400);
        exp_stat(F_MEM, 0, 32'h0);
        exp_stat(F_MEM, 1023, 32'hFFC);
        snap();

        // Reload one word from DONE
        start(1);
        exp_status(1, 1, 1, 0, 0);
        snap();
        exp_mem(0, 32'h20080005);
        send_word(32'h20080005);
        exp_status(0, 0, 0, 1, 0);
        exp_stat(F_WORDS, 0, 1);
        exp_stat(F_MEM, 1, 32'h4);
        exp_stat(F_MEM, 2, 32'h8);
        exp_stat(F_MEM, 1023, 32'hFFC);
        snap();

        drain = 1'b1;
        snap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
